// File: rtl/exu.sv
// ============================================================================
//  Module      : exu
//  Description : Execute stage. Latches one decoded instruction, computes the
//                ALU result, writeback data and jump target, and hands the
//                result to the LSU through a valid/allowin handshake.
//                Optional macro EXU_ITER_SHIFT_EN replaces the barrel shifter
//                with a one-bit-per-cycle iterative shifter (BUSY state).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADU_EXU_BUS_WIDTH
`define ADU_EXU_BUS_WIDTH 233
`endif
`ifndef EXU_LSU_BUS_WIDTH
`define EXU_LSU_BUS_WIDTH 159
`endif

module exu #(
  parameter int ADU_W = `ADU_EXU_BUS_WIDTH,
  parameter int LSU_W = `EXU_LSU_BUS_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adu_valid_i,
  input  logic [ADU_W-1:0] adu_exu_bus_i,
  output logic             exu_allowin_o,
  input  logic             lsu_allowin_i,
  output logic [LSU_W-1:0] exu_lsu_bus_o,
  output logic             valid_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] c_OP_ADD = 6'b110000;
  localparam logic [5:0] c_OP_SUB = 6'b110001;
  localparam logic [5:0] c_OP_XOR = 6'b010110;
  localparam logic [5:0] c_OP_OR  = 6'b011110;
  localparam logic [5:0] c_OP_AND = 6'b011000;
  localparam logic [5:0] c_OP_SLL = 6'b100000;
  localparam logic [5:0] c_OP_SRL = 6'b100001;
  localparam logic [5:0] c_OP_SRA = 6'b100011;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_accept_state;
  logic [ADU_W-1:0] r_bus;
  logic             r_first;
  logic             w_accept;
  logic             w_handoff;

  // Fields of the latched instruction
  logic        w_res_from_compare;
  logic        w_compare_result;
  logic        w_excp_flush;
  logic        w_xret_flush;
  logic        w_break_signal;
  logic [31:0] w_snpc;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [31:0] w_rs2_value;
  logic [5:0]  w_alu_op;
  logic        w_res_from_mem;
  logic        w_res_from_csr;
  logic        w_gr_we;
  logic        w_csr_we;
  logic [3:0]  w_mem_re;
  logic [3:0]  w_mem_we;
  logic [4:0]  w_rd;
  logic        w_jmp_flag;
  logic [11:0] w_csr_addr;
  logic [31:0] w_csr_wdata;
  logic [31:0] w_csr_value;

  assign {w_res_from_compare, w_compare_result, w_excp_flush, w_xret_flush,
          w_break_signal, w_snpc, w_src1, w_src2, w_rs2_value, w_alu_op,
          w_res_from_mem, w_res_from_csr, w_gr_we, w_csr_we, w_mem_re,
          w_mem_we, w_rd, w_jmp_flag, w_csr_addr, w_csr_wdata,
          w_csr_value} = r_bus;

  logic [31:0] w_sll;
  logic [31:0] w_srl;
  logic [31:0] w_sra;
  logic [31:0] w_alu_result;
  logic [31:0] w_wb_data;

`ifdef EXU_ITER_SHIFT_EN
  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] w_acc_step;
  logic [5:0]  w_in_op;
  logic [31:0] w_in_src1;
  logic [4:0]  w_in_shamt;

  assign w_in_op    = adu_exu_bus_i[99:94];
  assign w_in_src1  = adu_exu_bus_i[195:164];
  assign w_in_shamt = adu_exu_bus_i[136:132];

  // Shift ops park in BUSY; everything else completes in one cycle
  assign w_accept_state = (w_in_op[5:4] == 2'b10) ? BUSY : DONE;

  always_comb begin
    w_acc_step = r_acc;
    case (w_alu_op[1:0])
      2'b00:   w_acc_step = {r_acc[30:0], 1'b0};
      2'b01:   w_acc_step = {1'b0, r_acc[31:1]};
      2'b11:   w_acc_step = {r_acc[31], r_acc[31:1]};
      default: w_acc_step = r_acc;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= 5'd0;
      r_acc <= 32'd0;
    end else if (w_accept) begin
      r_cnt <= w_in_shamt;
      r_acc <= w_in_src1;
    end else if ((r_state == BUSY) && (r_cnt != 5'd0)) begin
      r_cnt <= r_cnt - 5'd1;
      r_acc <= w_acc_step;
    end
  end

  // Accumulator already holds the finished shift once DONE is reached
  assign w_sll = r_acc;
  assign w_srl = r_acc;
  assign w_sra = r_acc;
`else
  assign w_accept_state = DONE;
  assign w_sll = w_src1 << w_src2[4:0];
  assign w_srl = w_src1 >> w_src2[4:0];
  assign w_sra = $unsigned($signed(w_src1) >>> w_src2[4:0]);
`endif

  // Handshake
  assign valid_o       = (r_state == DONE);
  assign exu_allowin_o = (r_state == IDLE) | ((r_state == DONE) & lsu_allowin_i);
  assign w_accept      = adu_valid_i & exu_allowin_o;
  assign w_handoff     = valid_o & lsu_allowin_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_accept_state;
      DONE: if (w_handoff) w_state_nxt = w_accept ? w_accept_state : IDLE;
`ifdef EXU_ITER_SHIFT_EN
      BUSY: if (r_cnt == 5'd0) w_state_nxt = DONE;
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_bus   <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_bus <= adu_exu_bus_i;
      // Marks the first DONE cycle of each instruction for the redirect pulse
      r_first <= (w_state_nxt == DONE) && ((r_state != DONE) || w_accept);
    end
  end

  always_comb begin
    w_alu_result = 32'd0;
    case (w_alu_op)
      c_OP_ADD: w_alu_result = w_src1 + w_src2;
      c_OP_SUB: w_alu_result = w_src1 - w_src2;
      c_OP_XOR: w_alu_result = w_src1 ^ w_src2;
      c_OP_OR:  w_alu_result = w_src1 | w_src2;
      c_OP_AND: w_alu_result = w_src1 & w_src2;
      c_OP_SLL: w_alu_result = w_sll;
      c_OP_SRL: w_alu_result = w_srl;
      c_OP_SRA: w_alu_result = w_sra;
      default:  w_alu_result = 32'd0;
    endcase
  end

  always_comb begin
    w_wb_data = w_alu_result;
    if (w_res_from_compare)          w_wb_data = {31'd0, w_compare_result};
    else if (w_res_from_csr)         w_wb_data = w_csr_value;
    else if (w_jmp_flag && w_gr_we)  w_wb_data = w_snpc;
  end

  assign redirect_pc_o    = w_alu_result & ~32'h1;
  assign redirect_valid_o = valid_o & r_first & w_jmp_flag;

  assign exu_lsu_bus_o = {w_excp_flush, w_xret_flush, w_break_signal, w_gr_we,
                          w_csr_we, w_res_from_mem, w_mem_re, w_mem_we, w_rd,
                          w_alu_result, w_rs2_value, w_wb_data,
                          w_csr_addr, w_csr_wdata};

endmodule

`default_nettype wire

// File: tb/tb_exu.sv
// ============================================================================
//  Module      : tb_exu
//  Description : Directed self-checking bench for the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exu;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         adu_valid_i = 1'b0;
  logic [232:0] adu_exu_bus_i = '0;
  logic         exu_allowin_o;
  logic         lsu_allowin_i = 1'b0;
  logic [158:0] exu_lsu_bus_o;
  logic         valid_o;
  logic         redirect_valid_o;
  logic [31:0]  redirect_pc_o;

  int n_vec = 0;
  int n_err = 0;

  exu dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .adu_valid_i      (adu_valid_i),
    .adu_exu_bus_i    (adu_exu_bus_i),
    .exu_allowin_o    (exu_allowin_o),
    .lsu_allowin_i    (lsu_allowin_i),
    .exu_lsu_bus_o    (exu_lsu_bus_o),
    .valid_o          (valid_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction fields
  logic        f_rfc, f_cr, f_excp, f_xret, f_brk;
  logic [31:0] f_snpc, f_src1, f_src2, f_rs2;
  logic [5:0]  f_op;
  logic        f_rfm, f_rfcsr, f_gwe, f_csrwe, f_jmp;
  logic [3:0]  f_mre, f_mwe;
  logic [4:0]  f_rd;
  logic [11:0] f_caddr;
  logic [31:0] f_cwdata, f_cval;

  function automatic logic [232:0] pack();
    return {f_rfc, f_cr, f_excp, f_xret, f_brk, f_snpc, f_src1, f_src2, f_rs2,
            f_op, f_rfm, f_rfcsr, f_gwe, f_csrwe, f_mre, f_mwe, f_rd, f_jmp,
            f_caddr, f_cwdata, f_cval};
  endfunction

  function automatic logic [158:0] exp_bus(input logic [31:0] alu, input logic [31:0] wb);
    return {f_excp, f_xret, f_brk, f_gwe, f_csrwe, f_rfm, f_mre, f_mwe, f_rd,
            alu, f_rs2, wb, f_caddr, f_cwdata};
  endfunction

  function automatic int lat_of();
`ifdef EXU_ITER_SHIFT_EN
    if (f_op[5:4] == 2'b10) return int'(f_src2[4:0]) + 2;
`endif
    return 1;
  endfunction

  task automatic clr();
    {f_rfc, f_cr, f_excp, f_xret, f_brk} = '0;
    f_snpc = 32'h0; f_src1 = 32'h0; f_src2 = 32'h0; f_rs2 = 32'h0;
    f_op = 6'h0; {f_rfm, f_rfcsr, f_gwe, f_csrwe, f_jmp} = '0;
    f_mre = 4'h0; f_mwe = 4'h0; f_rd = 5'h0;
    f_caddr = 12'h0; f_cwdata = 32'h0; f_cval = 32'h0;
  endtask

  task automatic chk(input string tag, input logic [158:0] obs, input logic [158:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction with the LSU always ready and check its result
  task automatic send(input string tag, input logic [31:0] ea, input logic [31:0] ew,
                      input logic er);
    logic [158:0] e;
    int lat;
    e   = exp_bus(ea, ew);
    lat = lat_of();
    @(negedge clk_i);
    adu_exu_bus_i = pack(); adu_valid_i = 1'b1; lsu_allowin_i = 1'b1;
    #1 chk({tag, "/allowin"}, 159'(exu_allowin_o), 159'(1));
    @(posedge clk_i); #1;
    adu_valid_i = 1'b0;
    for (int i = 1; i < lat; i++) begin
      chk({tag, "/early_valid"}, 159'(valid_o), 159'(0));
      @(posedge clk_i); #1;
    end
    chk({tag, "/valid"},  159'(valid_o), 159'(1));
    chk({tag, "/bus"},    exu_lsu_bus_o, e);
    chk({tag, "/rvalid"}, 159'(redirect_valid_o), 159'(er));
    chk({tag, "/rpc"},    159'(redirect_pc_o), 159'(ea & ~32'h1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [158:0] e_a;
    logic [158:0] e_b;

    // Reset state
    #2;
    chk("rst/valid",  159'(valid_o), 159'(0));
    chk("rst/bus",    exu_lsu_bus_o, 159'(0));
    chk("rst/rvalid", 159'(redirect_valid_o), 159'(0));
    chk("rst/rpc",    159'(redirect_pc_o), 159'(0));
    @(negedge clk_i); rst_i = 1'b0;
    #1 chk("rst/allowin", 159'(exu_allowin_o), 159'(1));

    // add with overflow, pass-through fields populated
    clr(); f_op = 6'b110000; f_src1 = 32'h7FFF_FFFF; f_src2 = 32'h1; f_gwe = 1'b1;
    f_excp = 1'b1; f_brk = 1'b1; f_csrwe = 1'b1; f_rfm = 1'b1; f_mre = 4'hF;
    f_mwe = 4'h3; f_rd = 5'd3; f_rs2 = 32'hDEAD_BEEF; f_caddr = 12'h345;
    f_cwdata = 32'h1234_5678; f_cval = 32'hCAFE_F00D;
    send("add", 32'h8000_0000, 32'h8000_0000, 1'b0);

    clr(); f_op = 6'b110001; f_src1 = 32'h0; f_src2 = 32'h1; f_gwe = 1'b1; f_rd = 5'd7;
    send("sub", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    clr(); f_op = 6'b110001; f_src1 = 32'd5; f_src2 = 32'd3; f_rfc = 1'b1; f_cr = 1'b1;
    f_gwe = 1'b1; f_xret = 1'b1;
    send("cmp", 32'h0000_0002, 32'h0000_0001, 1'b0);

    clr(); f_op = 6'b010110; f_src1 = 32'hF0F0_F0F0; f_src2 = 32'hFF00_FF00;
    f_rfcsr = 1'b1; f_cval = 32'hCAFE_F00D; f_gwe = 1'b1; f_jmp = 1'b0;
    send("xor_csr", 32'h0FF0_0FF0, 32'hCAFE_F00D, 1'b0);

    clr(); f_op = 6'b011110; f_src1 = 32'h0F0F_0000; f_src2 = 32'h0000_00FF;
    send("or", 32'h0F0F_00FF, 32'h0F0F_00FF, 1'b0);

    clr(); f_op = 6'b011000; f_src1 = 32'hFFFF_0000; f_src2 = 32'h1234_5678;
    send("and", 32'h1234_0000, 32'h1234_0000, 1'b0);

    clr(); f_op = 6'b100000; f_src1 = 32'h1; f_src2 = 32'h0000_003F;
    send("sll31", 32'h8000_0000, 32'h8000_0000, 1'b0);

    clr(); f_op = 6'b100001; f_src1 = 32'h8000_0000; f_src2 = 32'd4;
    send("srl", 32'h0800_0000, 32'h0800_0000, 1'b0);

    clr(); f_op = 6'b100011; f_src1 = 32'h8000_0000; f_src2 = 32'd4;
    send("sra", 32'hF800_0000, 32'hF800_0000, 1'b0);

    clr(); f_op = 6'b100011; f_src1 = 32'h8765_4321; f_src2 = 32'd0;
    send("sra0", 32'h8765_4321, 32'h8765_4321, 1'b0);

    clr(); f_op = 6'b000000; f_src1 = 32'h1111_1111; f_src2 = 32'h2222_2222;
    send("badop", 32'h0, 32'h0, 1'b0);

    // Jump without writeback: wb falls back to alu_result
    clr(); f_op = 6'b110000; f_src1 = 32'h0000_1000; f_src2 = 32'h0000_0023;
    f_jmp = 1'b1; f_snpc = 32'h0000_0ABC;
    send("jmp_nowb", 32'h0000_1023, 32'h0000_1023, 1'b1);

    // Backpressure: A held while B waits
    clr(); f_op = 6'b110000; f_src1 = 32'd1; f_src2 = 32'd2; f_rd = 5'd1; f_gwe = 1'b1;
    e_a = exp_bus(32'd3, 32'd3);
    @(negedge clk_i);
    adu_exu_bus_i = pack(); adu_valid_i = 1'b1; lsu_allowin_i = 1'b1;
    @(posedge clk_i); #1;
    clr(); f_op = 6'b110001; f_src1 = 32'd10; f_src2 = 32'd4; f_rd = 5'd2; f_gwe = 1'b1;
    e_b = exp_bus(32'd6, 32'd6);
    @(negedge clk_i);
    adu_exu_bus_i = pack(); adu_valid_i = 1'b1; lsu_allowin_i = 1'b0;
    #1 chk("bp/allowin0", 159'(exu_allowin_o), 159'(0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      chk("bp/valid_hold",   159'(valid_o), 159'(1));
      chk("bp/bus_hold",     exu_lsu_bus_o, e_a);
      chk("bp/allowin_hold", 159'(exu_allowin_o), 159'(0));
    end
    @(negedge clk_i); lsu_allowin_i = 1'b1;
    #1 chk("bp/allowin1", 159'(exu_allowin_o), 159'(1));
    @(posedge clk_i); #1;
    adu_valid_i = 1'b0;
    chk("bp/valid_b", 159'(valid_o), 159'(1));
    chk("bp/bus_b",   exu_lsu_bus_o, e_b);

    // jalr: redirect pulses once despite a 3-cycle stall
    clr(); f_op = 6'b110000; f_src1 = 32'h8000_0101; f_src2 = 32'h10; f_jmp = 1'b1;
    f_gwe = 1'b1; f_snpc = 32'h8000_0008; f_rd = 5'd1;
    e_a = exp_bus(32'h8000_0111, 32'h8000_0008);
    @(negedge clk_i);
    adu_exu_bus_i = pack(); adu_valid_i = 1'b1; lsu_allowin_i = 1'b1;
    @(posedge clk_i); #1;
    adu_valid_i = 1'b0; lsu_allowin_i = 1'b0;
    chk("jalr/rvalid", 159'(redirect_valid_o), 159'(1));
    chk("jalr/rpc",    159'(redirect_pc_o), 159'(32'h8000_0110));
    chk("jalr/bus",    exu_lsu_bus_o, e_a);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("jalr/rvalid_stall", 159'(redirect_valid_o), 159'(0));
      chk("jalr/valid_stall",  159'(valid_o), 159'(1));
      chk("jalr/rpc_stall",    159'(redirect_pc_o), 159'(32'h8000_0110));
    end
    lsu_allowin_i = 1'b1;
    @(posedge clk_i); #1;
    chk("jalr/idle_valid",  159'(valid_o), 159'(0));
    chk("jalr/idle_rvalid", 159'(redirect_valid_o), 159'(0));

    // Async reset while DONE is stalled
    clr(); f_op = 6'b011110; f_src1 = 32'hA5A5_0000; f_src2 = 32'h0000_5A5A; f_rd = 5'd9;
    @(negedge clk_i);
    adu_exu_bus_i = pack(); adu_valid_i = 1'b1; lsu_allowin_i = 1'b0;
    @(posedge clk_i); #1;
    adu_valid_i = 1'b0;
    chk("rst2/pre_valid", 159'(valid_o), 159'(1));
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    chk("rst2/valid",  159'(valid_o), 159'(0));
    chk("rst2/bus",    exu_lsu_bus_o, 159'(0));
    chk("rst2/rpc",    159'(redirect_pc_o), 159'(0));
    chk("rst2/rvalid", 159'(redirect_valid_o), 159'(0));
    @(negedge clk_i); rst_i = 1'b0;
    #1 chk("rst2/allowin", 159'(exu_allowin_o), 159'(1));
    clr(); f_op = 6'b110000; f_src1 = 32'd100; f_src2 = 32'd23; f_gwe = 1'b1;
    send("post_rst", 32'd123, 32'd123, 1'b0);

`ifdef EXU_ITER_SHIFT_EN
    // Async reset in the middle of an iterative shift
    clr(); f_op = 6'b100001; f_src1 = 32'hFFFF_FFFF; f_src2 = 32'd20;
    @(negedge clk_i);
    adu_exu_bus_i = pack(); adu_valid_i = 1'b1; lsu_allowin_i = 1'b1;
    @(posedge clk_i); #1;
    adu_valid_i = 1'b0;
    chk("busy/allowin", 159'(exu_allowin_o), 159'(0));
    repeat (3) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("busy_rst/valid", 159'(valid_o), 159'(0));
    chk("busy_rst/bus",   exu_lsu_bus_o, 159'(0));
    @(negedge clk_i); rst_i = 1'b0;
    #1 chk("busy_rst/allowin", 159'(exu_allowin_o), 159'(1));
    clr(); f_op = 6'b100000; f_src1 = 32'h0000_0003; f_src2 = 32'd2;
    send("post_busy_rst", 32'h0000_000C, 32'h0000_000C, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exu.md
Name: exu

Overview:
Execute stage. It receives the 233-bit decode-to-execute bus and its valid signal from the decode stage and holds one instruction. It computes the ALU result, jump target and writeback data, then presents the 159-bit execute-to-memory bus to the LSU with a valid/allowin handshake. It also raises a one-cycle redirect to fetch when a jump or branch is taken.

Parameters:
- ADU_W, `ADU_EXU_BUS_WIDTH (233): input bus width.
- LSU_W, `EXU_LSU_BUS_WIDTH (159): output bus width. The macro is added to riscv_param.vh.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Asynchronous, active-high.
- adu_valid_i  in  1  input bus holds an instruction.
- adu_exu_bus_i  in  233  decode-to-execute bus. Fields, MSB first:
  - res_from_compare, compare_result, excp_flush, xret_flush, break_signal
  - snpc[32], src1[32], src2[32], rs2_value[32], alu_op[6]
  - res_from_mem, res_from_csr, gr_we, csr_we, mem_re[4], mem_we[4], rd[5], jmp_flag
  - csr_addr[12], csr_wdata[32], csr_value[32]
- exu_allowin_o  out  1  exu can accept this cycle.
- lsu_allowin_i  in  1  LSU can accept this cycle.
- exu_lsu_bus_o  out  159  execute-to-memory bus. Fields, MSB first:
  - excp_flush, xret_flush, break_signal, gr_we, csr_we, res_from_mem
  - mem_re[4], mem_we[4], rd[5]
  - alu_result[32], rs2_value[32], wb_data[32]
  - csr_addr[12], csr_wdata[32]
- valid_o  out  1  exu_lsu_bus_o is valid.
- redirect_valid_o  out  1  taken jump or branch, single-cycle pulse.
- redirect_pc_o  out  32  redirect target.

Behaviour:
- State machine states: IDLE (empty), BUSY (iterating, only with the macro), DONE (result held).
- Reset, asynchronous: state=IDLE, valid_o=0, redirect_valid_o=0, redirect_pc_o=0, exu_lsu_bus_o=0, all internal registers 0.
- exu_allowin_o = (state==IDLE) | (state==DONE & lsu_allowin_i). It is combinational.
- accept = adu_valid_i & exu_allowin_o. On accept, latch the whole input bus.
- Without the macro, the next state after accept is DONE, so latency is 1 cycle.
- valid_o = (state==DONE).
- handoff = valid_o & lsu_allowin_i.
- On handoff with no accept: go to IDLE.
- On handoff and accept in the same cycle: go straight to the new instruction's next state, with no bubble.
- While valid_o=1 and lsu_allowin_i=0, the output bus is held stable and no input is accepted.
- ALU, selected by alu_op. All 32-bit arithmetic wraps modulo 2^32. Shift amount = src2[4:0].
  - 110000: src1+src2
  - 110001: src1-src2
  - 010110: xor
  - 011110: or
  - 011000: and
  - 100000: sll
  - 100001: srl
  - 100011: sra
  - any other code: 0
- redirect_pc_o = alu_result & ~32'h1.
- redirect_valid_o = 1 only in the first DONE cycle of an instruction whose jmp_flag=1. It is 0 while that instruction stalls.
- wb_data priority:
  1. res_from_compare: {31'b0, compare_result}
  2. res_from_csr: csr_value
  3. jmp_flag & gr_we: snpc
  4. otherwise: alu_result
- res_from_mem loads: the LSU overrides wb_data; exu still drives alu_result as the address.
- All other output fields pass through unchanged from the latched bus.
- No flush input. excp, xret and break are forwarded only.
- adu_valid_i=0 leaves the block idle and the latched bus is not cleared.

Optional Feature:
- Macro EXU_ITER_SHIFT_EN defined: shift ops (alu_op[5:4]==2'b10) do not go to DONE on accept.
  - On accept: go to BUSY with cnt=shamt and acc=src1.
  - Each BUSY cycle: if cnt==0, go to DONE with alu_result=acc. Otherwise shift acc 1 bit (sra fills with the sign bit) and decrement cnt.
  - Accept-to-valid latency is shamt+2 cycles.
  - exu_allowin_o=0 throughout BUSY.
  - Reset in BUSY returns to IDLE.
  - Non-shift ops keep 1-cycle latency.
- Macro undefined: single-cycle barrel shifter. No BUSY state is synthesized.

Test Plan:
1. add: src1=0x7FFFFFFF, src2=1, gr_we=1 -> valid_o=1 one cycle after accept; alu_result=wb_data=0x80000000; redirect_valid_o=0.
2. sub: src1=0, src2=1 -> alu_result=0xFFFFFFFF.
   - Then compare with res_from_compare=1, compare_result=1 -> wb_data=0x00000001.
3. Backpressure: lsu_allowin_i=0 for 5 cycles with a second instruction waiting -> valid_o and bus stable, exu_allowin_o=0.
   - Then lsu_allowin_i=1 -> handoff and second accept in the same cycle; second result valid the next cycle.
4. jalr: src1=0x80000101, src2=0x10, jmp_flag=1, gr_we=1, snpc=0x80000008 -> redirect_pc_o=0x80000110 and redirect_valid_o pulses exactly once even with lsu_allowin_i=0 for 3 cycles; wb_data=0x80000008.
5. sra: src1=0x80000000, src2=4 -> alu_result=0xF8000000.
   - Latency 1 without EXU_ITER_SHIFT_EN, 6 with it.
   - shamt=0 with the macro -> latency 2, result=src1.
6. Reset: assert rst_i mid-BUSY, or while DONE is stalled -> all outputs 0 immediately (asynchronous); after release exu_allowin_o=1 and the next accept completes normally.
